// File: rtl/hazard_if.sv
// Handshake bundle between the RV32I pipeline datapath and its hazard controller.
// The datapath (master) supplies stage register indices and status, the controller (slave) answers.
interface hazard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] Rs1D;
  logic [ADDR_WIDTH-1:0] Rs2D;
  logic [ADDR_WIDTH-1:0] Rs1E;
  logic [ADDR_WIDTH-1:0] Rs2E;
  logic [ADDR_WIDTH-1:0] RdE;
  logic [ADDR_WIDTH-1:0] RdM;
  logic [ADDR_WIDTH-1:0] RdW;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  LoadE;
  logic                  PCSrcE;
  logic                  MemReqM;
  logic                  MemReadyM;

  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  StallW;
  logic                  FlushD;
  logic                  FlushE;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  MemErr;
  logic [CNT_WIDTH-1:0]  StallCount;
  logic [CNT_WIDTH-1:0]  FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    output ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline, with an M-stage
// memory-wait FSM (timeout -> sticky MemErr) and saturating stall/flush counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | no outstanding data access; pipeline advances normally
// ST_WAIT | M-stage access pending; pipeline frozen until ready/timeout
module hazard_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic                mem_err;
  logic                mem_stall;
  logic                lw_stall;
  logic                mem_miss;
  logic                wait_expired;
  logic                stall_f, stall_d, stall_e, stall_m, stall_w;
  logic                flush_d, flush_e;
  logic                any_stall;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_WIDTH-1:0] rs,
    input logic                  wr_m,
    input logic [ADDR_WIDTH-1:0] rd_m,
    input logic                  wr_w,
    input logic [ADDR_WIDTH-1:0] rd_w
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != '0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding is a pure function of the E/M/W register indices; reset does not gate it.
  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign mem_miss     = hz.MemReqM && !hz.MemReadyM;
  assign wait_expired = (state == ST_WAIT) && !hz.MemReadyM && (wcnt == TIMEOUT_V);

  assign mem_stall = ((state == ST_RUN) && mem_miss) ||
                     ((state == ST_WAIT) && !hz.MemReadyM && (wcnt < TIMEOUT_V));

  // A taken branch squashes the instruction in D, so its operands cannot cause a load-use hazard.
  assign lw_stall = hz.LoadE && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !hz.PCSrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (mem_miss) state_nxt = ST_WAIT;
      ST_WAIT: if (hz.MemReadyM || (wcnt == TIMEOUT_V)) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      stall_f = 1'b0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Ready takes precedence on the final wait cycle: a completed access is not an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      if ((state == ST_RUN) && mem_miss)
        wcnt <= WCNT_W'(1);
      else if ((state == ST_WAIT) && !hz.MemReadyM && (wcnt != TIMEOUT_V))
        wcnt <= wcnt + WCNT_W'(1);
      if (wait_expired)
        mem_err <= 1'b1;
    end
  end

  assign any_stall = stall_f | stall_d | stall_e | stall_m | stall_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (any_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_d && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.StallW     = stall_w;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.MemErr     = mem_err;
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan cases followed by random traffic,
// each cycle's expected response queued by the driver and checked by an independent monitor.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 6;
  localparam int TMO = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hif ();

  hazard_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] stall;
    logic [1:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_done = 1'b0;

  // reference model state
  bit m_waiting = 1'b0;
  int m_waited  = 0;
  bit m_err     = 1'b0;
  int m_sc      = 0;
  int m_fc      = 0;

  function automatic logic [1:0] ref_fwd(input int rs, input bit wm, input int rdm,
                                         input bit ww, input int rdw);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE = '0; hif.RdM = '0; hif.RdW = '0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.LoadE = 1'b0;
    hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
  endtask

  // Called just after a rising edge with the new inputs already applied.
  task automatic push_expect();
    exp_t e;
    bit req, rdy, hold_all, load_use;
    req = hif.MemReqM;
    rdy = hif.MemReadyM;
    e.fa = ref_fwd(int'(hif.Rs1E), hif.RegWriteM, int'(hif.RdM), hif.RegWriteW, int'(hif.RdW));
    e.fb = ref_fwd(int'(hif.Rs2E), hif.RegWriteM, int'(hif.RdM), hif.RegWriteW, int'(hif.RdW));
    if (rst) begin
      m_waiting = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
      e.stall = 5'b0; e.flush = 2'b0; e.err = 0; e.sc = 0; e.fc = 0;
      exp_q.push_back(e);
      return;
    end
    hold_all = m_waiting ? (!rdy && m_waited < TMO) : (req && !rdy);
    load_use = hif.LoadE && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D)
               && !hif.PCSrcE;
    if (hold_all)        begin e.stall = 5'b11111; e.flush = 2'b00; end
    else if (load_use)   begin e.stall = 5'b11000; e.flush = 2'b01; end
    else if (hif.PCSrcE) begin e.stall = 5'b00000; e.flush = 2'b11; end
    else                 begin e.stall = 5'b00000; e.flush = 2'b00; end
    e.err = m_err;
    e.sc  = m_sc;
    e.fc  = m_fc;
    exp_q.push_back(e);
    // advance model across the coming edge
    if (e.stall != 0 && m_sc < CMAX) m_sc++;
    if (e.flush[1] && m_fc < CMAX) m_fc++;
    if (!m_waiting) begin
      if (req && !rdy) begin m_waiting = 1; m_waited = 1; end
    end else if (rdy) begin
      m_waiting = 0;
    end else if (m_waited == TMO) begin
      m_waiting = 0; m_err = 1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic step();
    push_expect();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", int'({hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.StallW}), int'(e.stall));
      chk("flush", int'({hif.FlushD, hif.FlushE}), int'(e.flush));
      chk("fwd_a", int'(hif.ForwardAE), int'(e.fa));
      chk("fwd_b", int'(hif.ForwardBE), int'(e.fb));
      chk("mem_err", int'(hif.MemErr), int'(e.err));
      chk("stall_cnt", int'(hif.StallCount), e.sc);
      chk("flush_cnt", int'(hif.FlushCount), e.fc);
    end
  end

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // forwarding: M beats W, W alone, x0 never forwarded
    hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1; step();
    hif.RegWriteM = 0; step();
    set_idle(); hif.RdM = 0; hif.RegWriteM = 1; hif.Rs1E = 0; step();

    // load-use, then branch overriding load-use
    set_idle(); hif.LoadE = 1; hif.RdE = 3; hif.Rs2D = 3; step();
    set_idle(); hif.LoadE = 1; hif.RdE = 3; hif.Rs1D = 3; hif.PCSrcE = 1; step();

    // memory wait resolved by ready before timeout
    set_idle(); hif.MemReqM = 1; hif.MemReadyM = 0; step(); step();
    hif.MemReadyM = 1; step();
    set_idle(); step();

    // timeout with ready held low, memStall masking load-use and branch
    hif.MemReqM = 1; hif.LoadE = 1; hif.RdE = 2; hif.Rs1D = 2; hif.PCSrcE = 1;
    repeat (5) step();
    set_idle(); step(); step();

    // reset while waiting
    hif.MemReqM = 1; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    set_idle(); step();

    for (int i = 0; i < 3000; i++) begin
      hif.Rs1D = AW'($urandom_range(0, 3));
      hif.Rs2D = AW'($urandom_range(0, 3));
      hif.Rs1E = AW'($urandom_range(0, 3));
      hif.Rs2E = AW'($urandom_range(0, 3));
      hif.RdE  = AW'($urandom_range(0, 3));
      hif.RdM  = AW'($urandom_range(0, 3));
      hif.RdW  = AW'($urandom_range(0, 3));
      hif.RegWriteM = ($urandom_range(0, 1) == 1);
      hif.RegWriteW = ($urandom_range(0, 1) == 1);
      hif.LoadE     = ($urandom_range(0, 2) == 0);
      hif.PCSrcE    = ($urandom_range(0, 4) == 0);
      hif.MemReqM   = ($urandom_range(0, 2) == 0);
      hif.MemReadyM = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    set_idle();
    step();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    mon_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    if (!mon_done) begin
      $display("FAIL watchdog: run still active at %0t, expected to be finished", $time);
      $fatal(1, "watchdog expired");
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the 5-stage RV32I core.
- Drives stall and flush of the F/D/E/M/W pipeline registers, and E-stage operand-forwarding selects.
- Runs a memory-wait FSM with timeout for M-stage data accesses.
- Keeps saturating stall and flush performance counters.

## Interface
Parameters:
- ADDR_WIDTH, 5, register-index width
- CNT_WIDTH, 32, performance-counter width
- MEM_TIMEOUT, 255, max consecutive wait cycles before timeout (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Rs1D, Rs2D  in  ADDR_WIDTH  source regs of instr in D
- Rs1E, Rs2E, RdE  in  ADDR_WIDTH  source/dest regs in E
- RdM, RdW  in  ADDR_WIDTH  dest regs in M, W
- RegWriteM, RegWriteW  in  1  M/W instr writes register file
- LoadE  in  1  instr in E is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- MemReqM  in  1  M-stage data-memory access valid
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1  hold corresponding pipeline register
- FlushD, FlushE  out  1  zero D/E pipeline register
- ForwardAE, ForwardBE  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result
- MemErr  out  1  sticky memory-timeout flag
- StallCount, FlushCount  out  CNT_WIDTH  performance counters

## Operation
Forwarding (combinational, independent of rst/state):
- ForwardAE = 10 if RegWriteM && RdM≠0 && RdM==Rs1E.
- Else ForwardAE = 01 if RegWriteW && RdW≠0 && RdW==Rs1E.
- Else ForwardAE = 00.
- ForwardBE follows the same rules using Rs2E.
- M has priority over W.

Memory FSM (states RUN, WAIT) and wait counter wcnt:
- RUN → WAIT when MemReqM && !MemReadyM; wcnt ← 1.
- WAIT → RUN when MemReadyM.
- WAIT → RUN when wcnt == MEM_TIMEOUT: MemErr ← 1, released regardless of MemReadyM.
- Otherwise in WAIT, wcnt increments.
- memStall = (RUN && MemReqM && !MemReadyM) || (WAIT && !MemReadyM && wcnt < MEM_TIMEOUT).

Hazard terms:
- lwStall = LoadE && RdE≠0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
- A taken branch kills the wrong-path instr in D, so there is no load-use stall.

Output priority, combinational:
- rst high: all Stall*/Flush* = 0.
- memStall: StallF=StallD=StallE=StallM=StallW=1; FlushD=FlushE=0. The branch in E is held and resolves after release.
- Else lwStall: StallF=StallD=1, FlushE=1, all others 0.
- Else PCSrcE: FlushD=FlushE=1, all stalls 0.
- Else all 0.

Counters, registered and saturating at all-ones:
- StallCount +1 each cycle any Stall* is 1.
- FlushCount +1 each cycle FlushD is 1.

## Timing
Reset values:
- state=RUN, wcnt=0, MemErr=0, StallCount=0, FlushCount=0.
- All Stall*/Flush* = 0 while rst high.
- Reset mid-WAIT returns to RUN immediately.

Latency and timing:
- Stall/flush/forward outputs are same-cycle combinational.
- FSM state, MemErr and counters update on the clk rising edge.
- Memory miss stalls from the first cycle MemReqM && !MemReadyM is seen.
- Stall holds through the cycle MemReadyM rises; the pipeline advances on the edge after the ready cycle.
- Zero-wait access (MemReqM && MemReadyM in RUN) produces no stall and no state change.
- Timeout: stall asserted for exactly MEM_TIMEOUT cycles, then released. MemErr is visible on the following cycle and remains set until rst.
- Simultaneous lwStall, PCSrcE and memStall: memStall dominates. After release, PCSrcE overrides lwStall.
- Counters hold at 2^CNT_WIDTH−1; they do not wrap.

## Test plan
- Forwarding:
  - Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10.
  - Rs1E=5, RdM=5, RegWriteM=0, RdW=5, RegWriteW=1 -> ForwardAE=01.
  - RdM=0, RegWriteM=1, Rs1E=0 -> ForwardAE=00.
- Load-use: LoadE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle. FlushCount unchanged; StallCount +1.
- Branch vs load-use: LoadE=1, RdE=3, Rs1D=3, PCSrcE=1 -> FlushD=FlushE=1, StallF=0. FlushCount +1.
- Memory wait: MemReqM=1, MemReadyM low 4 cycles then high -> all five stalls high 5 cycles, state back to RUN, StallCount +5, MemErr=0.
- Timeout with MEM_TIMEOUT=3: MemReqM=1, MemReadyM held 0 -> stalls high exactly 3 cycles, then 0. MemErr=1 from the next cycle, persisting until rst.
- Reset mid-WAIT: assert rst asynchronously in WAIT -> all Stall* drop immediately; counters=0, MemErr=0. After rst deasserts, the FSM is in RUN.
